// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states
// and the access legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } lsu_state_e;

    // Misaligned, illegal-size or beyond the end of the data memory.
    function automatic logic access_error(input lsu_size_e size,
                                          input logic [31:0] addr,
                                          input int unsigned mem_words);
        logic        err;
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr[0];
            SZ_WORD: err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if (word_idx >= mem_words) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// sub-word store data into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase
        half_sel = lane[1] ? rd[31:16] : rd[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: load_data = rd;
        endcase
    end

    always_comb begin
        merged = rd;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-only data memory;
// sub-word stores are done as read-merge-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state;
    lsu_size_e   size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    lsu_size_e   req_size_e;

    assign req_size_e = lsu_size_e'(req_size);

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (addr_q[1:0]),
        .rd          (mem_rd),
        .wdata       (wd_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            size_q    <= SZ_BYTE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size_e;
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        wd_q      <= req_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (access_error(req_size_e, req_addr, MEM_WORDS)) begin
                            rsp_err <= 1'b1;
                            state   <= RESP;
                        end else if (req_we && req_size_e == SZ_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                // wd_q holds store data until here, then the merged word
                READ: begin
                    if (we_q) begin
                        wd_q  <= merged;
                        state <= WRITE;
                    end else begin
                        rsp_rdata <= load_data;
                        state     <= RESP;
                    end
                end
                WRITE: state <= RESP;
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_we    = (state == WRITE) && !RST;
    assign mem_wd    = (state == WRITE) ? wd_q : '0;
    assign mem_a     = (state == IDLE) ? '0 : {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random traffic
// checked against a byte-level memory model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 64;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Downstream memory with a backdoor port used only for preloading.
    logic [31:0] dut_mem [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    assign mem_rd = dut_mem[mem_a[7:2]];

    always @(posedge CLK) begin
        if (mem_we) dut_mem[mem_a[7:2]] <= mem_wd;
        else if (bd_we) dut_mem[bd_idx] <= bd_data;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          pulses;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Reference model: byte-granular view of memory, applies stores to ref_mem.
    task automatic model(input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd, output exp_t e);
        int          nbytes;
        int          off;
        int          idx;
        logic [31:0] val;
        nbytes = (sz == 2'd3) ? 1 : (1 << sz);
        off    = int'(a % 4);
        idx    = int'(a / 4);
        e.err  = (sz == 2'd3) || (a % nbytes != 0) || (a / 4 >= MEM_WORDS);
        e.rdata = '0;
        if (e.err) begin
            e.lat = 1;
            e.pulses = 0;
        end else if (!we) begin
            val = '0;
            for (int i = 0; i < nbytes; i++)
                val[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
            if (nbytes < 4 && !uns && val[8*nbytes-1])
                for (int i = nbytes; i < 4; i++) val[8*i +: 8] = 8'hFF;
            e.rdata = val;
            e.lat = 2;
            e.pulses = 0;
        end else begin
            for (int i = 0; i < nbytes; i++)
                ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
            e.lat = (nbytes == 4) ? 2 : 3;
            e.pulses = 1;
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the acceptance edge.
    task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                          input bit [31:0] a, input bit [31:0] wd, input bit push,
                          output logic [31:0] exp_rdata);
        exp_t e;
        int   k;
        k = 0;
        exp_rdata = '0;
        while (!req_ready && k < 100) begin
            @(posedge CLK); #2;
            k++;
        end
        if (!req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        if (push) begin
            model(we, sz, uns, a, wd, e);
            sb.push_back(e);
            exp_rdata = e.rdata;
        end
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge CLK); #2;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || !req_ready) && k < 200) begin
            @(posedge CLK); #2;
            k++;
        end
        if (sb.size() != 0 || !req_ready) fail_now("drain");
    endtask

    // Response consumer
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge CLK); #2;
            rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency, stability under backpressure, response contents.
    int          n = 0;
    int          accept_n = 0;
    int          we_cnt = 0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_e = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            n++;
            if (RST) begin
                prev_v = 1'b0;
                continue;
            end
            if (mem_we) we_cnt++;
            if (req_valid && req_ready) begin
                accept_n = n;
                we_cnt = 0;
            end
            if (rsp_valid) begin
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                if (!prev_v) begin
                    if (sb.size() == 0) fail_now("unexpected_response");
                    else chk("latency", 32'(n - accept_n), 32'(sb[0].lat));
                end else if (!prev_r) begin
                    chk("stall_rdata_stable", rsp_rdata, prev_d);
                    chk("stall_err_stable", 32'(rsp_err), 32'(prev_e));
                end
                if (rsp_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("mem_we_pulses", 32'(we_cnt), 32'(e.pulses));
                end
            end
            prev_v = rsp_valid;
            prev_r = rsp_ready;
            prev_d = rsp_rdata;
            prev_e = rsp_err;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        logic [31:0] r;
        bit   [1:0]  sz;
        bit   [31:0] a;

        RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        @(posedge CLK); #2;
        for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            r = (i == 5) ? 32'h8899AABB : $urandom;
            ref_mem[i] = r;
            bd_we = 1'b1; bd_idx = 6'(i); bd_data = r;
            @(posedge CLK); #2;
        end
        bd_we = 1'b0;
        @(posedge CLK); #2;
        RST = 1'b0;
        #3;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wd", mem_wd, 32'd0);
        @(posedge CLK); #2;

        // Directed: word load, signed/unsigned byte, half store, error cases
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, exp_d);
        chk("word_load_model", exp_d, 32'h8899AABB);
        do_req(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 1'b1, exp_d);
        do_req(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 1'b1, exp_d);
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1234, 1'b1, exp_d);
        drain();
        chk("half_store_mem", dut_mem[5], 32'h1234AABB);
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b1, exp_d);
        do_req(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 1'b1, exp_d);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, exp_d);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, exp_d);
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, 1'b1, exp_d);
        drain();

        // Backpressure: response must hold for four stalled cycles
        stall = 1'b1;
        @(posedge CLK); #2;
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, exp_d);
        begin
            int k;
            k = 0;
            while (!rsp_valid && k < 20) begin
                @(posedge CLK); #2;
                k++;
            end
            if (!rsp_valid) fail_now("bp_rsp_wait");
        end
        repeat (4) begin
            @(posedge CLK); #2;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, exp_d);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        stall = 1'b0;
        drain();

        // Reset during the WRITE cycle of a word store
        r = dut_mem[0];
        do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, exp_d);
        RST = 1'b1;
        #3;
        chk("rst_write_mem_we", 32'(mem_we), 32'd0);
        @(posedge CLK); #2;
        RST = 1'b0;
        chk("rst_write_req_ready", 32'(req_ready), 32'd1);
        chk("rst_write_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (4) @(posedge CLK);
        #2;
        chk("rst_write_mem0", dut_mem[0], r);
        chk("rst_write_no_rsp", 32'(rsp_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            sz = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 4*MEM_WORDS + 7));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1, exp_d);
        end
        drain();

        for (int unsigned i = 0; i < MEM_WORDS; i++)
            chk("final_mem_word", dut_mem[i], ref_mem[i]);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, giving the number of 32-bit words in the downstream data memory; in-range word index < MEM_WORDS.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: request present.
REQ-005 SHALL have port req_ready, output, 1 bit: unit can accept a request.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: zero-extend loads when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: consumer accepts response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: misaligned, illegal-size or out-of-range access.
REQ-015 SHALL have ports mem_we (out, 1), mem_a (out, 32), mem_wd (out, 32) and mem_rd (in, 32): a word-only memory port with synchronous write and combinational read.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE and RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid & req_ready, and capture the address, data, size, we and unsigned fields.
REQ-018 SHALL flag an error when any of these holds: size 11; half with addr[0]=1; word with addr[1:0]≠00; addr[31:2] ≥ MEM_WORDS.
REQ-019 SHALL use these transitions out of IDLE on acceptance:
- error → RESP;
- word store → WRITE;
- load or sub-word store → READ.
REQ-020 In READ, SHALL sample mem_rd.
- Load: → RESP, with the extracted and extended data registered into rsp_rdata.
- Sub-word store: → WRITE, with the merged word registered.
REQ-021 In WRITE, SHALL drive mem_we = 1 for exactly one cycle, with mem_wd = full word (word store) or merged word (sub-word store), then → RESP.
REQ-022 In RESP, SHALL hold rsp_valid = 1 and keep rsp_rdata/rsp_err stable until rsp_ready = 1, then → IDLE.
REQ-023 SHALL drive mem_a = {captured addr[31:2], 2'b00} in every state other than IDLE, and mem_a = 0 in IDLE.
REQ-024 SHALL use little-endian byte lanes.
- Byte: lane addr[1:0].
- Half: lane addr[1].
- Merge: replaces only the addressed lane(s) with the low bits of wdata.
REQ-025 SHALL assert rsp_valid in this many cycles after the acceptance edge:
- error: 1;
- load: 2;
- word store: 2;
- sub-word store: 3.
REQ-026 SHALL never assert mem_we for an erroring request or for any load.
REQ-027 SHALL ignore req_valid while not in IDLE; there is no queuing.

Reset
REQ-028 With RST = 1 at an edge, SHALL enter IDLE and clear all outputs to 0 except req_ready, which reads 1 after reset.
REQ-029 SHALL gate mem_we with !RST, so that a reset asserted during WRITE performs no memory write.
REQ-030 SHALL abort any in-flight request on reset mid-operation, with no response issued.

Structure
REQ-031 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enumeration in shared package lsu_pkg.
REQ-032 SHALL place lane extraction, extension and merge in one combinational sub-module, lsu_align.

Verification
REQ-033 Word load: mem word 5 = 0x8899AABB; load word at 0x14 → rsp_rdata 0x8899AABB, err 0, rsp_valid 2 cycles after accept.
REQ-034 Signed byte load: the same word; load byte signed at 0x17 → 0xFFFFFF88; unsigned → 0x00000088.
REQ-035 Half store: store half 0x1234 at 0x16 over 0x8899AABB → memory word 0x1234AABB, exactly one mem_we pulse, rsp_valid 3 cycles after accept.
REQ-036 Errors: load word at 0x13, half at 0x15, size 11, and word at 0x100 (MEM_WORDS = 64) → each rsp_err 1, rsp_rdata 0, no mem_we, rsp_valid 1 cycle after accept.
REQ-037 Response backpressure: rsp_ready held 0 for 4 cycles → rsp_valid and rsp_rdata stable, req_ready 0 throughout.
REQ-038 Reset in WRITE: RST = 1 during the WRITE cycle of a word store of 0xDEADBEEF at 0x0 → memory unchanged, IDLE, req_ready 1, no response.
